// File: rtl/adc_link_pkg.sv
// rtl/adc_link_pkg.sv - shared ADC link widths, band labels and label classification
package adc_link_pkg;

    localparam int FRAME_PAYLOAD_W = 12;
    localparam int FREQ_W          = 6;
    localparam int AMP_W           = 4;
    localparam int LABEL_W         = 2;

    localparam logic [LABEL_W-1:0] LBL_LOW  = 2'b00;
    localparam logic [LABEL_W-1:0] LBL_MID  = 2'b01;
    localparam logic [LABEL_W-1:0] LBL_HIGH = 2'b10;
    localparam logic [LABEL_W-1:0] LBL_OOR  = 2'b11;

    localparam int DEF_LOW_MAX = 10;
    localparam int DEF_MID_MAX = 28;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // Band a transmitter should attach to a frequency; freq 0 is never a real tone.
    function automatic logic [LABEL_W-1:0] expected_label(input logic [FREQ_W-1:0] freq,
                                                          input int low_max,
                                                          input int mid_max);
        logic [LABEL_W-1:0] lbl;
        if (freq == '0)
            lbl = LBL_OOR;
        else if (int'(freq) <= low_max)
            lbl = LBL_LOW;
        else if (int'(freq) <= mid_max)
            lbl = LBL_MID;
        else
            lbl = LBL_HIGH;
        return lbl;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - rx line synchroniser and bit-period counter with mid-bit strobe
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    input  logic run,
    input  logic half_period,
    output logic rx_sync,
    output logic mid_sample
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic [CNT_W-1:0] cnt;

    // Line presets to idle-high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    // The half-period strobe during the start bit re-aligns every later strobe to mid-bit.
    always_comb begin
        mid_sample = run && (cnt == (half_period ? HALF_LAST : FULL_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset || !run || mid_sample)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/adc_word_receiver.sv
// rtl/adc_word_receiver.sv - serial ADC word receiver with framing/parity/label checks
module adc_word_receiver
    import adc_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int LOW_MAX      = DEF_LOW_MAX,
    parameter int MID_MAX      = DEF_MID_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_in,
    output logic [FREQ_W-1:0]  freq_out,
    output logic [AMP_W-1:0]   amp_out,
    output logic [LABEL_W-1:0] label_out,
    output logic               label_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_err,
    output logic               overrun
);

    rx_state_t                  state, state_nxt;
    logic [3:0]                 bit_cnt;
    logic [FRAME_PAYLOAD_W-1:0] shift_reg;
    logic                       parity_ok;
    logic                       rx_sync, mid_sample, timer_run, timer_half;
    logic                       frame_done, frame_good, load_word;
    logic [FREQ_W-1:0]          rx_freq;
    logic [AMP_W-1:0]           rx_amp;
    logic [LABEL_W-1:0]         rx_label;

    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .run         (timer_run),
        .half_period (timer_half),
        .rx_sync     (rx_sync),
        .mid_sample  (mid_sample)
    );

    // Payload arrives LSB first, so after 12 right shifts amp[0] sits at bit 0.
    assign rx_amp   = shift_reg[AMP_W-1:0];
    assign rx_freq  = shift_reg[AMP_W +: FREQ_W];
    assign rx_label = shift_reg[AMP_W+FREQ_W +: LABEL_W];

    always_ff @(posedge clk) begin
        if (reset)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        timer_run  = (state != RX_IDLE) && (state != RX_WAIT_IDLE);
        timer_half = (state == RX_START);
        frame_done = 1'b0;
        frame_good = rx_sync && parity_ok;
        unique case (state)
            RX_IDLE:      if (!rx_sync) state_nxt = RX_START;
            RX_START:     if (mid_sample) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (mid_sample && bit_cnt == 4'(FRAME_PAYLOAD_W - 1)) state_nxt = RX_PARITY;
            RX_PARITY:    if (mid_sample) state_nxt = RX_STOP;
            RX_STOP: begin
                if (mid_sample) begin
                    frame_done = 1'b1;
                    state_nxt  = rx_sync ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: if (rx_sync) state_nxt = RX_IDLE;
            default:      state_nxt = RX_IDLE;
        endcase
        load_word = frame_done && frame_good && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity_ok <= 1'b0;
        end else if (mid_sample) begin
            if (state == RX_START)
                bit_cnt <= '0;
            if (state == RX_DATA) begin
                shift_reg <= {rx_sync, shift_reg[FRAME_PAYLOAD_W-1:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end
            if (state == RX_PARITY)
                parity_ok <= ((^shift_reg) == rx_sync);
        end
    end

    // An accept on the same cycle as a load frees the slot, so that case loads without overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            freq_out  <= '0;
            amp_out   <= '0;
            label_out <= '0;
            label_err <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_done && !frame_good;
            overrun   <= frame_done && frame_good && !load_word;
            if (load_word) begin
                freq_out  <= rx_freq;
                amp_out   <= rx_amp;
                label_out <= rx_label;
                label_err <= (rx_label != expected_label(rx_freq, LOW_MAX, MID_MAX));
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
